// File: rtl/gbn_tx_controller.sv
// Go-Back-N transmit controller: numbers upstream payloads, keeps a retransmit
// buffer for the open window and resends from the window base on timeout.
module gbn_tx_controller #(
    parameter int N         = 4,
    parameter int SEQ_WIDTH = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pkt_valid,
    input  logic [8-SEQ_WIDTH-1:0] pkt_data,
    output logic                   pkt_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic                   ack_valid,
    input  logic [SEQ_WIDTH-1:0]   ack_seq,
    output logic [SEQ_WIDTH-1:0]   base_seq,
    output logic [SEQ_WIDTH-1:0]   next_seq,
    output logic                   window_full,
    output logic [7:0]             retx_count
);

    localparam int PW = 8 - SEQ_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, SEND, RETX} state_t;

    state_t               state;
    logic [SEQ_WIDTH-1:0] ptr;
    logic [TW-1:0]        timer;
    logic                 retx_pending;
    logic [PW-1:0]        frame_buf [N];

    logic [SEQ_WIDTH-1:0] outstanding;
    logic [SEQ_WIDTH-1:0] ack_dist;
    logic [SEQ_WIDTH-1:0] new_base;
    logic [SEQ_WIDTH-1:0] new_outstanding;
    logic [SEQ_WIDTH-1:0] ptr_inc;
    logic [SEQ_WIDTH-1:0] load_ptr;
    logic                 ack_ok;
    logic                 accept;

    // Window bookkeeping; load_ptr skips frames an ACK has already retired.
    always_comb begin
        outstanding     = next_seq - base_seq;
        ack_dist        = ack_seq - base_seq;
        ack_ok          = ack_valid && (ack_dist < outstanding);
        new_base        = ack_ok ? (ack_seq + SEQ_WIDTH'(1)) : base_seq;
        new_outstanding = next_seq - new_base;
        ptr_inc         = ptr + SEQ_WIDTH'(1);
        load_ptr        = ((ptr - new_base) < new_outstanding) ? ptr : new_base;
        pkt_ready       = (state == IDLE) && (outstanding < SEQ_WIDTH'(N)) && !retx_pending;
        window_full     = (outstanding == SEQ_WIDTH'(N));
        accept          = pkt_valid && pkt_ready;
    end

    always_ff @(posedge clk) begin
        if (accept)
            frame_buf[next_seq[IW-1:0]] <= pkt_data;
    end

    // A valid ACK also drops a pending timeout, so an emptied window never stalls intake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            base_seq     <= '0;
            next_seq     <= '0;
            ptr          <= '0;
            timer        <= '0;
            retx_pending <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= '0;
            retx_count   <= '0;
        end else begin
            if (ack_ok) begin
                base_seq     <= new_base;
                timer        <= '0;
                retx_pending <= 1'b0;
            end else if (outstanding == '0) begin
                timer <= '0;
            end else if (state != RETX) begin
                if (timer == TW'(TIMEOUT - 1))
                    retx_pending <= 1'b1;
                else
                    timer <= timer + TW'(1);
            end

            case (state)
                IDLE: begin
                    if (retx_pending && (outstanding != '0)) begin
                        state        <= RETX;
                        ptr          <= base_seq;
                        retx_pending <= 1'b0;
                        timer        <= '0;
                        if (retx_count != 8'hFF)
                            retx_count <= retx_count + 8'd1;
                    end else if (accept) begin
                        tx_data  <= {pkt_data, next_seq};
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        next_seq <= next_seq + SEQ_WIDTH'(1);
                        state    <= IDLE;
                    end
                end
                RETX: begin
                    if (tx_valid) begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            ptr      <= ptr_inc;
                            if ((ptr_inc == next_seq) || (new_base == next_seq)) begin
                                state <= IDLE;
                                timer <= '0;
                            end
                        end
                    end else if (new_outstanding == '0) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        ptr      <= load_ptr;
                        tx_data  <= {frame_buf[load_ptr[IW-1:0]], load_ptr};
                        tx_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gbn_tx_controller.md
Name: gbn_tx_controller

Overview:
Go-Back-N transmit-side controller that pairs with the team's Go-Back-N receiver. It accepts 5-bit payloads from upstream, tags each with a SEQ_WIDTH-bit sequence number, and stores each in an N-entry retransmit buffer. It drives frames onto the link under a valid/ready handshake, tracks cumulative ACKs, and on timeout resends every outstanding frame starting from the window base.

Parameters:
N, 4, window size; power of two; must satisfy N < 2**SEQ_WIDTH
SEQ_WIDTH, 3, sequence-number width; frame bits [SEQ_WIDTH-1:0]
TIMEOUT, 16, clock cycles without base advance before go-back retransmission

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
pkt_valid  input  1  upstream payload available
pkt_data  input  8-SEQ_WIDTH  payload
pkt_ready  output  1  payload accepted when pkt_valid && pkt_ready
tx_data  output  8  frame = {payload, seq}
tx_valid  output  1  frame valid
tx_ready  input  1  link accepts frame
ack_valid  input  1  cumulative ACK strobe
ack_seq  input  SEQ_WIDTH  highest in-order sequence number received
base_seq  output  SEQ_WIDTH  oldest unacknowledged sequence number
next_seq  output  SEQ_WIDTH  next new sequence number
window_full  output  1  outstanding == N
retx_count  output  8  number of timeout events, saturating at 255

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; base_seq=0, next_seq=0, timer=0; retx pending flag cleared.
  - tx_valid=0, tx_data=0, retx_count=0.
  - Buffer contents are don't-care. A reset mid-transfer drops tx_valid at once.
- Sequence arithmetic is modulo 2**SEQ_WIDTH.
  - outstanding = (next_seq - base_seq) mod 2**SEQ_WIDTH, range 0..N.
  - Buffer index = seq mod N.
- pkt_ready (combinational) = state==IDLE && outstanding<N && !retx_pending.
- FSM states: IDLE, SEND, RETX.
  - IDLE:
    - If retx_pending and outstanding>0: go to RETX, ptr<=base_seq, retx_pending<=0, retx_count++ (saturating), timer<=0.
    - Else on pkt_valid && pkt_ready: buf[next_seq mod N]<=pkt_data, tx_data<={pkt_data,next_seq}, tx_valid<=1, go to SEND.
  - SEND:
    - Hold tx_valid and tx_data stable until tx_ready.
    - On handshake: tx_valid<=0, next_seq++, go to IDLE.
    - If outstanding was 0 at the handshake, the timer starts from 0.
  - RETX:
    - Load tx_data<={buf[ptr mod N],ptr}, tx_valid<=1; hold until tx_ready.
    - On handshake: ptr++. If the new ptr == next_seq, go to IDLE with timer<=0; otherwise load the next frame the following cycle.
    - Throughput: one frame per 2 cycles minimum.
- ACK processing happens in every state.
  - An ACK is valid when d=(ack_seq - base_seq) mod 2**SEQ_WIDTH satisfies d<outstanding.
  - On a valid ACK: base_seq<=ack_seq+1, timer<=0.
  - Invalid or duplicate ACKs are ignored with no state change.
- ACK during RETX:
  - If the new base is beyond ptr, the next load uses ptr<=new base.
  - A frame already presented (tx_valid=1) is never retracted.
  - If the ACK empties the window, RETX ends after the current handshake. If no frame is presented when the window empties, RETX ends the next cycle.
- Timer:
  - Increments each cycle while outstanding>0 and state!=RETX.
  - Held at 0 when outstanding==0.
  - On reaching TIMEOUT-1 it sets retx_pending. A SEND in progress completes first, then IDLE enters RETX.
- Simultaneous events:
  - A valid ACK in the same cycle as timer expiry wins: the timer clears and retx_pending is not set.
  - ACK plus SEND handshake in the same cycle: both update; outstanding is recomputed from the new values.
- Wrap: next_seq 7→0 and base_seq 7→0 behave as normal modulo increments.
- window_full = (outstanding==N), registered-consistent with base_seq and next_seq.

Test Plan:
1. Basic send: reset, tx_ready=1, push payloads 0x01..0x03 → tx_data=0x08,0x11,0x1A; next_seq=3; ACK 2 → base_seq=3, window_full=0.
2. Window full: push 4 frames with no ACK → pkt_ready=0 while window_full=1; ACK 1 → pkt_ready=1, base_seq=2.
3. Timeout: send seq 0..2, no ACK for 16 cycles → frames seq 0,1,2 resent in order with identical payloads; retx_count=1; back to IDLE.
4. ACK during RETX: ACK 0 while seq 0 is being presented → after that handshake, the next resent frame is seq 1; ACK 2 → RETX ends, outstanding=0.
5. Wrap and stale ACK: drive next_seq across 7→0 with ACKs tracking; then a stale ACK (seq 5 when base_seq=1) → no change.
6. Reset mid-operation: assert reset while tx_valid=1 and tx_ready=0 → tx_valid=0 immediately; base_seq=next_seq=0, retx_count=0.
